// File: rtl/signed_or_unsigned_div.sv
// signed_or_unsigned_div: iterative restoring divider that retires one quotient
// bit per clock. It works on operand magnitudes and applies the sign fixup on
// the final step. Each operation selects signed or unsigned through signed_div.
// Optional feature macro: SIGNED_OR_UNSIGNED_DIV_EARLY_ZERO_EN. When it is
// defined, a zero divisor skips the iterations and returns its result one
// edge after acceptance.
module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Working registers (data only, no reset)
  logic [n-1:0]  dq;       // dividend magnitude shifting out, quotient bits shifting in
  logic [n-1:0]  pr;       // partial remainder, always below the divisor magnitude
  logic [n-1:0]  bmag;
  logic [n-1:0]  a_hold;   // original dividend, returned as remainder on divide by zero
  logic          q_neg;
  logic          r_neg;
  logic          b_zero;

  logic [n:0]    trial;
  logic          fits;
  logic [n-1:0]  pr_nxt;
  logic [n-1:0]  dq_nxt;

  // Magnitude in n+1-bit signed width so the most-negative value maps to 2^(n-1)
  function automatic logic [n-1:0] mag(input logic [n-1:0] v, input logic sgn);
    logic signed [n:0] ext;
    ext = {sgn & v[n-1], v};
    if (ext[n]) ext = -ext;
    return ext[n-1:0];
  endfunction

  // Two's-complement negation when the result must be negative
  function automatic logic [n-1:0] apply_sign(input logic [n-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  // One restoring shift-subtract step
  always_comb begin
    trial  = {pr, dq[n-1]};
    fits   = (trial >= {1'b0, bmag});
    pr_nxt = fits ? n'(trial - {1'b0, bmag}) : trial[n-1:0];
    dq_nxt = {dq[n-2:0], fits};
  end

  // Datapath: capture operands on acceptance, iterate while in CALC
  always_ff @(posedge clk) begin
    if (state == IDLE && arg_vld) begin
      dq     <= mag(a, signed_div);
      pr     <= '0;
      bmag   <= mag(b, signed_div);
      a_hold <= a;
      q_neg  <= signed_div & (a[n-1] ^ b[n-1]);
      r_neg  <= signed_div & a[n-1];
      b_zero <= (b == '0);
    end else if (state == CALC) begin
      dq <= dq_nxt;
      pr <= pr_nxt;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      arg_rdy     <= 1'b1;
      res_vld     <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arg_vld) begin
            state   <= CALC;
            arg_rdy <= 1'b0;
`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_ZERO_EN
            cnt     <= (b == '0) ? CW'(1) : CW'(n);
`else
            cnt     <= CW'(n);
`endif
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            res_vld <= 1'b1;
            if (b_zero) begin
              quot        <= '1;
              rem         <= a_hold;
              div_by_zero <= 1'b1;
            end else begin
              quot        <= apply_sign(dq_nxt, q_neg);
              rem         <= apply_sign(pr_nxt, r_neg);
              div_by_zero <= 1'b0;
            end
          end
        end
        DONE: begin
          if (res_rdy) begin
            state   <= IDLE;
            res_vld <= 1'b0;
            arg_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Testbench for signed_or_unsigned_div (n = 8): directed cases plus
// randomized operands checked against an arithmetic reference model.
module tb_signed_or_unsigned_div;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         arg_vld;
  logic         arg_rdy;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_div;
  logic         res_vld;
  logic         res_rdy;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         div_by_zero;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  signed_or_unsigned_div #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .arg_vld     (arg_vld),
    .arg_rdy     (arg_rdy),
    .a           (a),
    .b           (b),
    .signed_div  (signed_div),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic (SV division truncates toward zero)
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic ms,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    int sa, sb, qi, ri;
    if (mb == 0) begin
      q = '1; r = ma; z = 1'b1;
    end else if (!ms) begin
      q = ma / mb; r = ma % mb; z = 1'b0;
    end else begin
      sa = $signed(ma);
      sb = $signed(mb);
      qi = sa / sb;
      ri = sa - qi * sb;
      q  = qi[N-1:0];
      r  = ri[N-1:0];
      z  = 1'b0;
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] eb);
`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_ZERO_EN
    return (eb == 0) ? 1 : N;
`else
    return N;
`endif
  endfunction

  // Present operands and let the accepting edge E0 pass
  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts);
    @(negedge clk);
    a = ta; b = tb; signed_div = ts; arg_vld = 1'b1;
    chk("arg_rdy_before_accept", 32'(arg_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    chk("arg_rdy_after_accept", 32'(arg_rdy), 32'd0);
  endtask

  // Count edges after E0 until res_vld is seen (bounded)
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_vld && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                              input logic ts, input int lat);
    logic [N-1:0] eq, er;
    logic         ez;
    model(ta, tb, ts, eq, er, ez);
    chk({tag, "_lat"},  32'(lat),         32'(exp_lat(tb)));
    chk({tag, "_quot"}, 32'(quot),        32'(eq));
    chk({tag, "_rem"},  32'(rem),         32'(er));
    chk({tag, "_dbz"},  32'(div_by_zero), 32'(ez));
  endtask

  task automatic release_result();
    res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_rdy = 1'b0;
    chk("res_vld_drop", 32'(res_vld), 32'd0);
    chk("arg_rdy_rise", 32'(arg_rdy), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic ts);
    int lat;
    start_op(ta, tb, ts);
    wait_result(lat);
    check_result(tag, ta, tb, ts, lat);
    release_result();
  endtask

  initial begin
    int lat;
    logic [N-1:0] ra, rb;
    logic rs;

    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0;
    a = '0; b = '0; signed_div = 1'b0;
    #1;
    chk("rst_arg_rdy", 32'(arg_rdy), 32'd1);
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_quot",    32'(quot),    32'd0);
    chk("rst_rem",     32'(rem),     32'd0);
    chk("rst_dbz",     32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("u200_7",   8'd200, 8'd7,   1'b0);
    run_op("s_m7_2",   8'hF9,  8'h02,  1'b1);
    run_op("u_f9_2",   8'hF9,  8'h02,  1'b0);
    run_op("s_ovf",    8'h80,  8'hFF,  1'b1);
    run_op("s_zero",   8'h55,  8'h00,  1'b1);
    run_op("u_zero",   8'h55,  8'h00,  1'b0);
    run_op("s_m128_1", 8'h80,  8'h01,  1'b1);
    run_op("s_7_m2",   8'h07,  8'hFE,  1'b1);
    run_op("u_255_1",  8'hFF,  8'h01,  1'b0);
    run_op("u_3_200",  8'd3,   8'd200, 1'b0);

    // Backpressure: hold res_rdy low while offering new operands
    start_op(8'd200, 8'd7, 1'b0);
    wait_result(lat);
    check_result("bp_first", 8'd200, 8'd7, 1'b0, lat);
    a = 8'd9; b = 8'd3; signed_div = 1'b0; arg_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_vld",  32'(res_vld), 32'd1);
      chk("bp_hold_rdy",  32'(arg_rdy), 32'd0);
      chk("bp_hold_quot", 32'(quot),    32'd28);
      chk("bp_hold_rem",  32'(rem),     32'd4);
    end
    res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_rdy = 1'b0;
    chk("bp_release_vld", 32'(res_vld), 32'd0);
    chk("bp_release_rdy", 32'(arg_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    chk("bp_accept_rdy", 32'(arg_rdy), 32'd0);
    wait_result(lat);
    check_result("bp_second", 8'd9, 8'd3, 1'b0, lat);
    release_result();

    // Reset three edges into CALC
    start_op(8'd200, 8'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",  32'(res_vld), 32'd0);
    chk("mid_rst_rdy",  32'(arg_rdy), 32'd1);
    chk("mid_rst_quot", 32'(quot),    32'd0);
    chk("mid_rst_rem",  32'(rem),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_9_3", 8'd9, 8'd3, 1'b0);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rs = 1'($urandom);
      run_op("rand", ra, rb, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/signed_or_unsigned_div.md
# signed_or_unsigned_div

Iterative parameterized divider that produces either a signed or an unsigned quotient and remainder of two n-bit operands, selected per operation by the `signed_div` input. It is the inverse companion of the combinational signed/unsigned multiplier. It trades area for latency by retiring one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so it drops into the sequential arithmetic pipelines of the design.

## Interface
- `n`, default 8, operand, quotient and remainder width (n ≥ 2).
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset; asynchronous and active-high (one clock domain, `clk`).
- `arg_vld`  input  1  operands valid.
- `arg_rdy`  output  1  divider can accept operands.
- `a`  input  n  dividend.
- `b`  input  n  divisor.
- `signed_div`  input  1  1 = two's-complement division, 0 = unsigned; sampled with the operands.
- `res_vld`  output  1  result valid.
- `res_rdy`  input  1  consumer accepts the result.
- `quot`  output  n  quotient.
- `rem`  output  n  remainder.
- `div_by_zero`  output  1  the current result came from b == 0.

## Operation
- States: IDLE, CALC, DONE.
- Reset: state IDLE; `arg_rdy`=1; `res_vld`=0; `quot`, `rem`=0; `div_by_zero`=0.
- IDLE:
  - `arg_rdy`=1.
  - On `arg_vld`&&`arg_rdy`, latch `a`, `b` and `signed_div`, load the iteration counter with n, and go to CALC.
- CALC:
  - Restoring shift-subtract on magnitudes; one quotient bit per edge; the counter decrements.
  - On the last step, apply the sign fixup and register `quot`/`rem`, then go to DONE.
- DONE:
  - `res_vld`=1, and `quot`/`rem`/`div_by_zero` stay stable.
  - On `res_rdy`, go to IDLE; `res_vld` drops on the same edge.
- Unsigned mode: `quot` = floor(a/b), `rem` = a − quot·b.
- Signed mode:
  - Quotient truncates toward zero.
  - `rem` takes the sign of `a`; |rem| < |b|.
  - Magnitude of the most-negative value is handled in n+1-bit internal width.
- Signed overflow, a = −2^(n−1) and b = −1: `quot` = −2^(n−1) (wraps), `rem`=0, `div_by_zero`=0.
- b == 0, either mode: `quot` = all ones, `rem` = a, `div_by_zero`=1.
- No overlap between operations. A new operand is accepted at the earliest one cycle after the result handshake.
- `arg_vld` in CALC or DONE is ignored, because `arg_rdy`=0.
- `res_rdy` outside DONE has no effect.
- Reset asserted mid-CALC or in DONE: the operation is discarded and the block immediately shows reset values.

## Timing
- The accepting edge is E0.
- Normal latency: `res_vld` rises after edge E0+n (n iteration edges).
- Throughput: at best one result per n+2 cycles.
- `arg_rdy` falls after E0 and rises after the edge where `res_vld`&&`res_rdy`.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SIGNED_OR_UNSIGNED_DIV_EARLY_ZERO_EN`.
- Defined:
  - b == 0 is detected at acceptance, CALC is skipped, and DONE is entered on E0+1 with the divide-by-zero result.
  - Latency is 1 for that case only.
- Undefined: b == 0 runs the full n iterations and produces the identical result after E0+n.
- Nonzero divisors behave the same either way.

## Test plan
- n=8, unsigned, a=200, b=7 -> `quot`=28, `rem`=4, `div_by_zero`=0; `res_vld` after exactly 8 edges.
- Signed, a=8'hF9 (−7), b=8'h02 -> `quot`=8'hFD (−3), `rem`=8'hFF (−1). The same operands unsigned -> `quot`=124, `rem`=1.
- Signed, a=8'h80, b=8'hFF -> `quot`=8'h80, `rem`=0, `div_by_zero`=0.
- a=8'h55, b=0, signed and unsigned -> `quot`=8'hFF, `rem`=8'h55, `div_by_zero`=1. Latency is 1 edge with the macro defined and 8 edges without.
- Result backpressure: hold `res_rdy`=0 for 5 cycles in DONE while driving `arg_vld`=1 with new operands.
  - During the hold: outputs stay stable, `arg_rdy`=0, and nothing is accepted.
  - After releasing `res_rdy`: `res_vld` falls, and the new operands are accepted on the next edge.
- Assert `rst` 3 edges into CALC -> `res_vld`=0, `arg_rdy`=1, `quot`=`rem`=0 immediately. A following unsigned 9/3 gives `quot`=3, `rem`=0.
